// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random generator: tap table and per-cycle operation codes.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 32;
  localparam int unsigned LFSR_MIN_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_RECOVER
  } lfsr_op_e;

  // Primitive-polynomial tap masks; bit (t-1) set for each tap t of x^t.
  function automatic logic [31:0] taps(input int unsigned width);
    logic [31:0] m;
    case (width)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic bit width_is_legal(input int unsigned width);
    return (width >= LFSR_MIN_WIDTH) && (width <= LFSR_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Free-running maximal-length Fibonacci LFSR (shift-left) with seed load,
// wrap pulse on return to SEED and recovery from the all-zero lockup state.
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(taps(WIDTH));

  generate
    if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("lfsr_rng: WIDTH must be within 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_rng: SEED must be non-zero");
    end
  endgenerate

  logic [WIDTH-1:0] r_state;
  logic             r_wrap;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_state_d;
  logic             w_wrap_d;
  lfsr_op_e         w_op;

  assign w_fb       = ^(r_state & TAP_MASK);
  assign w_next     = {r_state[WIDTH-2:0], w_fb};
  assign w_load_val = (seed_in == '0) ? SEED : seed_in;

  // Zero state outranks load/en so a fault can never persist past one clock.
  always_comb begin
    w_op = OP_HOLD;
    if (r_state == '0) begin
      w_op = OP_RECOVER;
    end else if (load) begin
      w_op = OP_LOAD;
    end else if (en) begin
      w_op = OP_STEP;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_wrap_d  = 1'b0;
    case (w_op)
      OP_RECOVER: w_state_d = SEED;
      OP_LOAD:    w_state_d = w_load_val;
      OP_STEP: begin
        w_state_d = w_next;
        w_wrap_d  = (w_next == SEED);
      end
      default:    w_state_d = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wrap  <= w_wrap_d;
    end
  end

  assign out  = r_state;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_lfsr_rng.sv
// Scoreboard bench for lfsr_rng: directed steps queue expected out/wrap, a monitor compares.
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [9:0] seed_in;
  logic [9:0] out;
  logic       wrap;

  logic        rst_s, en_s;
  logic [2:0]  out3;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic        wrap3, wrap8, wrap16;

  always #5 clk = ~clk;

  lfsr_rng #(.WIDTH(10), .SEED(10'h001)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .out(out), .wrap(wrap)
  );
  lfsr_rng #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst_s), .en(en_s), .load(1'b0), .seed_in(3'd0), .out(out3), .wrap(wrap3)
  );
  lfsr_rng #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_s), .en(en_s), .load(1'b0), .seed_in(8'd0), .out(out8), .wrap(wrap8)
  );
  lfsr_rng #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst_s), .en(en_s), .load(1'b0), .seed_in(16'd0), .out(out16), .wrap(wrap16)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  out;
    logic        wrap;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int unsigned cycle = 0;
  int          total = 0;
  int          bad   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: pop every expectation due on this cycle and compare against the DUT.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.cyc < cycle) begin
          total++;
          bad++;
          $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", nm, e.cyc, cycle);
        end else begin
          check({nm, "_out"}, 32'(out), 32'(e.out));
          check({nm, "_wrap"}, 32'(wrap), 32'(e.wrap));
        end
      end
    end
  end

  task automatic drive(input logic e, input logic l, input logic [9:0] s, input bit chk,
                       input logic [9:0] eo, input logic ew, input string nm);
    exp_t x;
    en      = e;
    load    = l;
    seed_in = s;
    if (chk) begin
      x.cyc  = cycle + 1;
      x.out  = eo;
      x.wrap = ew;
      exp_q.push_back(x);
      name_q.push_back(nm);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          seen[1024];
  int          first_ret, wraps, repeats, zeros, distinct;
  logic [15:0] so[3];
  logic        sw[3];
  logic        prev_w[3];
  int          per[3];
  int          fr[3], wf[3], wbad[3], wcons[3];

  initial begin
    rst = 1'b0; en = 1'b1; load = 1'b0; seed_in = '0;
    rst_s = 1'b0; en_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'h001);
    check("reset_wrap", 32'(wrap), 0);

    rst = 1'b1;
    drive(1, 0, '0, 1, 10'h002, 0, "step1");
    repeat (4) drive(1, 0, '0, 0, '0, 0, "");
    drive(1, 0, '0, 1, 10'h040, 0, "step6");
    drive(1, 0, '0, 1, 10'h081, 0, "step7");
    drive(1, 0, '0, 0, '0, 0, "");
    drive(1, 0, '0, 1, 10'h204, 0, "step9");
    drive(1, 0, '0, 1, 10'h009, 0, "step10");

    // Full period from a fresh reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    first_ret = 0; wraps = 0; repeats = 0; zeros = 0; distinct = 0;
    for (int s = 1; s <= 1024; s++) begin
      drive(1, 0, '0, (s >= 1022), (s == 1022) ? 10'h200 : (s == 1023) ? 10'h001 : 10'h002,
            (s == 1023), "period_edge");
      if (s <= 1023) begin
        if (seen[out]) repeats++;
        else distinct++;
        seen[out] = 1'b1;
      end
      if (out == '0) zeros++;
      if (out == 10'h001 && first_ret == 0) first_ret = s;
      if (wrap) wraps++;
    end
    check("period_len", 32'(first_ret), 1023);
    check("period_wraps", 32'(wraps), 1);
    check("period_repeats", 32'(repeats), 0);
    check("period_zeros", 32'(zeros), 0);
    check("period_distinct", 32'(distinct), 1023);

    for (int i = 0; i < 20; i++) drive(0, 0, '0, 1, 10'h002, 0, "hold");
    drive(1, 1, 10'h2A5, 1, 10'h2A5, 0, "load_wins");
    drive(1, 0, '0, 1, 10'h14B, 0, "after_load");
    drive(0, 1, 10'h000, 1, 10'h001, 0, "load_zero");
    drive(0, 1, 10'h200, 1, 10'h200, 0, "load_200");
    drive(1, 0, '0, 1, 10'h001, 1, "wrap_from_load");
    drive(1, 0, '0, 1, 10'h002, 0, "wrap_single");
    drive(1, 1, 10'h001, 1, 10'h001, 0, "load_seed_nowrap");
    drive(1, 0, '0, 1, 10'h002, 0, "pre_async");
    en = 1'b0;

    #2;
    rst = 1'b0;
    #1;
    check("async_out", 32'(out), 32'h001);
    check("async_wrap", 32'(wrap), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, '0, 1, 10'h001, 0, "post_reset_hold");
    drive(1, 0, '0, 1, 10'h002, 0, "restart");
    en = 1'b0;

    // Width sweep: three instances stepped together.
    per = '{7, 255, 65535};
    for (int k = 0; k < 3; k++) begin
      fr[k] = 0; wf[k] = 0; wbad[k] = 0; wcons[k] = 0; prev_w[k] = 1'b0;
    end
    rst_s = 1'b1;
    en_s  = 1'b1;
    for (int s = 1; s <= 65540; s++) begin
      @(negedge clk);
      so[0] = {13'd0, out3};  sw[0] = wrap3;
      so[1] = {8'd0, out8};   sw[1] = wrap8;
      so[2] = out16;          sw[2] = wrap16;
      for (int k = 0; k < 3; k++) begin
        if (so[k] == 16'd1 && fr[k] == 0) fr[k] = s;
        if (sw[k] && s <= per[k]) wf[k]++;
        if (sw[k] != (so[k] == 16'd1)) wbad[k]++;
        if (sw[k] && prev_w[k]) wcons[k]++;
        prev_w[k] = sw[k];
      end
    end
    en_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sweep%0d_period", k), 32'(fr[k]), 32'(per[k]));
      check($sformatf("sweep%0d_wraps", k), 32'(wf[k]), 1);
      check($sformatf("sweep%0d_wrap_at_seed", k), 32'(wbad[k]), 0);
      check($sformatf("sweep%0d_wrap_consec", k), 32'(wcons[k]), 0);
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
